// File: rtl/uart_tx_frame_timer.sv
// UART transmit sequencer: accepts a parallel word and drives a framed serial
// line (start, LSB-first data, optional parity, 1-2 stop bits). Bit timing is
// counted in oversample ticks supplied by a shared baud-tick generator.
module uart_tx_frame_timer #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 sample_tick_i,
    input  logic                 start_i,
    input  logic [DATA_BITS-1:0] data_in_i,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 tx_out_o,
    output logic                 shift_strobe_o,
    output logic                 done_o
);

    localparam int unsigned SampleCntW = $clog2(OVERSAMPLE);
    localparam int unsigned BitCntW    = $clog2(DATA_BITS + 1);

    localparam logic [SampleCntW-1:0] SampleLast = SampleCntW'(OVERSAMPLE - 1);
    localparam logic [BitCntW-1:0]    DataLast   = BitCntW'(DATA_BITS - 1);
    localparam logic [BitCntW-1:0]    StopLast   = BitCntW'(STOP_BITS - 1);
    localparam logic                  ParityEn   = (PARITY_EN != 0);
    localparam logic                  ParityOdd  = (PARITY_ODD != 0);

    // Reject illegal configurations at elaboration time.
    if (OVERSAMPLE < 2) begin : g_bad_oversample
        $fatal(1, "uart_tx_frame_timer: OVERSAMPLE must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $fatal(1, "uart_tx_frame_timer: DATA_BITS must be in 5..9");
    end
    if (PARITY_EN > 1) begin : g_bad_parity_en
        $fatal(1, "uart_tx_frame_timer: PARITY_EN must be 0 or 1");
    end
    if (PARITY_ODD > 1) begin : g_bad_parity_odd
        $fatal(1, "uart_tx_frame_timer: PARITY_ODD must be 0 or 1");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $fatal(1, "uart_tx_frame_timer: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                 state_q, state_d;
    logic [SampleCntW-1:0]  sample_cnt_q, sample_cnt_d;
    logic [BitCntW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   strobe_q, strobe_d;
    logic                   done_q, done_d;
    logic                   bit_end;

    // In the done cycle the FSM is still in StStop (done_q=1) so that start is
    // blocked there; the following edge returns to StIdle unconditionally.
    assign bit_end = sample_tick_i && (sample_cnt_q == SampleLast) && !done_q;

    // Next-state, counter, shift-register and registered-output logic.
    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        busy_d       = busy_q;
        strobe_d     = 1'b0;
        done_d       = 1'b0;
        tx_d         = 1'b1;

        // Oversample counter runs only inside a frame and only on ticks.
        if (state_q != StIdle && !done_q && sample_tick_i) begin
            sample_cnt_d = bit_end ? '0 : sample_cnt_q + SampleCntW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    shift_d      = data_in_i;
                    parity_d     = (^data_in_i) ^ ParityOdd;
                    sample_cnt_d = '0;
                    bit_cnt_d    = '0;
                    busy_d       = 1'b1;
                    state_d      = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    strobe_d  = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    strobe_d = 1'b1;
                    shift_d  = shift_q >> 1;
                    if (bit_cnt_q == DataLast) begin
                        bit_cnt_d = '0;
                        state_d   = ParityEn ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitCntW'(1);
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    strobe_d  = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (done_q) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else if (bit_end) begin
                    strobe_d = 1'b1;
                    if (bit_cnt_q == StopLast) begin
                        done_d    = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitCntW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase

        // Serial line value is registered from the upcoming state.
        unique case (state_d)
            StIdle:   tx_d = 1'b1;
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = parity_d;
            StStop:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

    // State and output registers; reset forces an idle, high line at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            strobe_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            strobe_q     <= strobe_d;
            done_q       <= done_d;
        end
    end

    // Ready is a pure state decode; everything else comes straight from flops.
    assign ready_o        = (state_q == StIdle);
    assign busy_o         = busy_q;
    assign tx_out_o       = tx_q;
    assign shift_strobe_o = strobe_q;
    assign done_o         = done_q;

endmodule

// File: tb/tb_uart_tx_frame_timer.sv
// Bench for uart_tx_frame_timer: three instances (8N1, 8E1, 8O2) share tick,
// data and reset; expected line bits are queued when a frame is launched and
// popped mid-bit as the frame plays out.
module tb_uart_tx_frame_timer;

    localparam int OS = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       tick_hold;
    logic       tick_raw;
    logic       sample_tick;
    int         tick_period = 1;
    int         tcnt = 0;
    logic [2:0] start_v;
    logic [7:0] data_in;
    logic [2:0] ready_v, busy_v, tx_v, strobe_v, done_v;

    int tests = 0;
    int fails = 0;
    logic exp_q[$];

    int pe[3] = '{0, 1, 1};
    int po[3] = '{0, 0, 1};
    int sb[3] = '{1, 1, 2};

    // Tick generator: one pulse every tick_period cycles, maskable by tick_hold.
    always @(posedge clk) begin
        if (tcnt >= tick_period - 1) tcnt <= 0;
        else                         tcnt <= tcnt + 1;
    end
    assign tick_raw    = (tcnt == 0);
    assign sample_tick = tick_raw & ~tick_hold;

    uart_tx_frame_timer u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .sample_tick_i(sample_tick), .start_i(start_v[0]),
        .data_in_i(data_in), .ready_o(ready_v[0]), .busy_o(busy_v[0]), .tx_out_o(tx_v[0]),
        .shift_strobe_o(strobe_v[0]), .done_o(done_v[0])
    );

    uart_tx_frame_timer #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .sample_tick_i(sample_tick), .start_i(start_v[1]),
        .data_in_i(data_in), .ready_o(ready_v[1]), .busy_o(busy_v[1]), .tx_out_o(tx_v[1]),
        .shift_strobe_o(strobe_v[1]), .done_o(done_v[1])
    );

    uart_tx_frame_timer #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .sample_tick_i(sample_tick), .start_i(start_v[2]),
        .data_in_i(data_in), .ready_o(ready_v[2]), .busy_o(busy_v[2]), .tx_out_o(tx_v[2]),
        .shift_strobe_o(strobe_v[2]), .done_o(done_v[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send one frame on instance sel, called and returning at a falling edge.
    // hold_at/disturb_at/abort_at are tick counts (-1 = unused).
    task automatic frame(input int sel, input logic [7:0] d, input int hold_at,
                         input int disturb_at, input int abort_at, input bit start_in_done);
        int   nbits, ticks, strobes, cycles, first_sc, last_sc;
        bit   tk, got_done, held, disturbed, stable;
        logic ref_tx;
        nbits = 1 + 8 + pe[sel] + sb[sel];
        ticks = 0; strobes = 0; cycles = 0; first_sc = -1; last_sc = -1;
        got_done = 0; held = 0; disturbed = 0;

        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (pe[sel] != 0) exp_q.push_back((^d) ^ (po[sel] != 0));
        for (int i = 0; i < sb[sel]; i++) exp_q.push_back(1'b1);

        check($sformatf("ready_before_%0d", sel), ready_v[sel], 1);
        data_in      = d;
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
        check("accept_busy", busy_v[sel], 1);
        check("accept_ready", ready_v[sel], 0);
        check("accept_tx", tx_v[sel], 0);

        while (!got_done && cycles < 4000) begin
            if (hold_at >= 0 && !held && ticks == hold_at) begin
                held      = 1;
                tick_hold = 1'b1;
                ref_tx    = tx_v[sel];
                stable    = 1;
                repeat (100) begin
                    @(negedge clk);
                    if (tx_v[sel] !== ref_tx || strobe_v[sel] !== 1'b0) stable = 0;
                end
                check("hold_freeze", stable, 1);
                tick_hold = 1'b0;
            end
            if (disturb_at >= 0 && !disturbed && ticks == disturb_at) begin
                disturbed    = 1;
                start_v[sel] = 1'b1;
                data_in      = ~d;
            end else begin
                start_v[sel] = 1'b0;
            end
            if (abort_at >= 0 && ticks == abort_at) begin
                check("busy_pre_abort", busy_v[sel], 1);
                rst_n = 1'b0;
                #1;
                check("abort_tx", tx_v[sel], 1);
                check("abort_busy", busy_v[sel], 0);
                check("abort_ready", ready_v[sel], 1);
                check("abort_strobe", strobe_v[sel], 0);
                exp_q.delete();
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            tk = sample_tick;
            @(negedge clk);
            cycles++;
            if (tk) ticks++;
            if (strobe_v[sel]) begin
                strobes++;
                if (first_sc < 0) first_sc = cycles;
                last_sc = cycles;
            end
            if (tk && (ticks % OS) == OS / 2 && exp_q.size() > 0)
                check($sformatf("bit%0d_dut%0d", ticks / OS, sel), tx_v[sel], exp_q.pop_front());
            if (done_v[sel]) got_done = 1;
        end
        start_v[sel] = 1'b0;

        check("done_seen", got_done, 1);
        check("frame_ticks", ticks, nbits * OS);
        check("strobe_count", strobes, nbits);
        check("queue_empty", exp_q.size(), 0);
        check("busy_in_done", busy_v[sel], 1);
        check("ready_in_done", ready_v[sel], 0);
        if (hold_at < 0)
            check("strobe_span", last_sc - first_sc, (nbits - 1) * OS * tick_period);
        exp_q.delete();

        if (start_in_done) begin
            start_v[sel] = 1'b1;
            data_in      = 8'h00;
        end
        @(negedge clk);
        start_v[sel] = 1'b0;
        check("ready_after", ready_v[sel], 1);
        check("busy_after", busy_v[sel], 0);
        check("done_after", done_v[sel], 0);
        check("tx_after", tx_v[sel], 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        tick_hold = 1'b0;
        start_v   = '0;
        data_in   = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", ready_v[0], 1);
        check("rst_busy", busy_v[0], 0);
        check("rst_tx", tx_v[0], 1);
        check("rst_strobe", strobe_v[0], 0);
        check("rst_done", done_v[0], 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 8N1 basic frame
        frame(0, 8'hA5, -1, -1, -1, 0);
        // Even parity, then odd parity with two stop bits
        frame(1, 8'h07, -1, -1, -1, 0);
        frame(1, 8'h03, -1, -1, -1, 0);
        frame(2, 8'h07, -1, -1, -1, 0);
        frame(2, 8'h03, -1, -1, -1, 0);
        // Mid-frame start with data change, start in done cycle, then back-to-back
        frame(0, 8'h5A, -1, 40, -1, 1);
        frame(0, 8'hC3, -1, -1, -1, 0);
        // Slow ticks, then a long tick gap mid-bit
        tick_period = 3;
        frame(0, 8'h96, -1, -1, -1, 0);
        frame(0, 8'h69, 56, -1, -1, 0);
        tick_period = 1;
        repeat (3) @(negedge clk);
        // Asynchronous reset in the middle of data bit 4, then a clean frame
        frame(0, 8'hFF, -1, -1, 88, 0);
        frame(0, 8'h3C, -1, -1, -1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
